de_ex_stage: RTL and testbench
==============================

# de_ex_stage

Decode-to-execute pipeline register with operand resolution. Sits directly downstream of the forwarding unit: it takes the per-source forward selects and the load-use stall, muxes register-file, EX, and MEM data into the final operands, and registers them for execute. It also captures operands while execute back-pressures, so that a forwarded value is not lost when its producer leaves the forwarding window. Flush and bubble insertion are handled here.

## Interface
- CTRL_W, 16, width of opaque decoded control bundle passed through to execute
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- de_valid  in  1  decode holds a valid instruction
- de_rs1, de_rs2, de_rd  in  5 each  source/destination register numbers
- de_pc, de_imm  in  32 each  instruction PC, decoded immediate
- de_ctrl  in  CTRL_W  decoded control bundle
- rf_rdata1, rf_rdata2  in  32 each  register-file read data
- forward_rs1, forward_rs2  in  2 each  NOT_FORWARDING / FORWARDING_EX / FORWARDING_MEM (defines.vh)
- load_stall  in  1  load-use hazard, hold decode
- ex_fwd_data, mem_fwd_data  in  32 each  results of instructions in EX and MEM
- ex_ready  in  1  execute accepts dx contents this cycle
- flush  in  1  redirect; kill decode instruction and dx register
- de_ready  out  1  decode may present a new instruction next cycle
- dx_valid  out  1  dx register holds an instruction
- dx_pc, dx_imm, dx_op1, dx_op2  out  32 each  registered PC, immediate, resolved operands
- dx_rd  out  5; dx_ctrl  out  CTRL_W
- stall_count  out  32  decode stall cycles (see Configuration)

## Operation
- Resolve per source n: if hold_n set, use held_n. Else use the value selected by forward_rsn: NOT_FORWARDING selects rf_rdatan, FORWARDING_EX selects ex_fwd_data, FORWARDING_MEM selects mem_fwd_data. The unused encoding selects rf_rdatan.
- slot_free = ~dx_valid | ex_ready.
- adv = de_valid & ~load_stall & slot_free & ~flush.
- de_ready = ~de_valid | adv | flush (combinational).
- dx register update, in priority order:
  - flush: dx_valid <= 0.
  - adv: load all dx_* from the de_* inputs and the resolved operands; dx_valid <= 1.
  - ex_ready: dx_valid <= 0. This covers both consumption and bubble insertion when load_stall is high.
  - Otherwise: hold.
- Hold FSM, one per source, with states LIVE and HELD (hold_n = HELD):
  - LIVE -> HELD when de_valid & ~adv & ~flush & ~load_stall. This is a back-pressure block; latch the resolved value into held_n.
  - HELD -> LIVE on adv or flush.
  - Never capture while load_stall is high, because the forwarded load data is not yet valid.
- dx_* data fields are don't-care when dx_valid is 0. They keep their last loaded value.

## Timing
- Reset values: dx_valid 0, all dx_* 0, hold flags LIVE, held values 0, stall_count 0.
- Latency: an instruction accepted (adv) in cycle t appears with dx_valid=1 in t+1.
- Full-throughput case: with ex_ready held at 1 and no stalls, one instruction moves per cycle.
- de_ready, adv and the operand mux are combinational from the inputs. All dx_* outputs are registered.
- Simultaneous flush and adv: flush wins, nothing is loaded.
- Simultaneous load_stall and ex_ready: a bubble is inserted and the decode instruction holds.
- Reset asserted mid-stall: the hold flags clear and dx_valid drops on the next edge.

## Configuration
- DE_STALL_COUNT_EN defined:
  - stall_count increments on each cycle with de_valid & ~adv & ~flush.
  - It saturates at 32'hFFFFFFFF and clears on reset.
- DE_STALL_COUNT_EN undefined: stall_count is tied to 32'd0 and no counter logic is synthesised.

## Test plan
- Straight-line flow: ex_ready=1, de_valid=1, forward=NOT, rf_rdata1=32'h11 -> next cycle dx_valid=1, dx_op1=32'h11; one instruction per cycle.
- EX forward: forward_rs2=FORWARDING_EX, ex_fwd_data=32'hABCD, rf_rdata2=0 -> dx_op2=32'hABCD.
- Load-use stall: load_stall=1 for 1 cycle with ex_ready=1 -> dx_valid=0 bubble, de_ready=0. The next cycle advances with FORWARDING_MEM data, dx_op1=mem_fwd_data.
- Back-pressure capture:
  - Stimulus: ex_ready=0 for 3 cycles, forward_rs1=FORWARDING_MEM, mem_fwd_data=32'h55 in the first cycle. The select then changes to NOT with rf_rdata1=32'h99.
  - Required: on release, dx_op1=32'h55.
- Flush during stall: ex_ready=0, de_valid=1, flush=1 -> next cycle dx_valid=0, hold flags LIVE, de_ready=1 during the flush cycle.
- Counter (DE_STALL_COUNT_EN): 4 back-pressure cycles from reset -> stall_count=4. Without the macro -> stall_count stays 0.

Source files
------------

// File: rtl/de_ex_stage.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// de_ex_stage
//
// Decode-to-execute pipeline register with operand resolution. Muxes the
// register-file, EX and MEM forwarded data into the final operands and
// registers them for execute. While execute back-pressures, the resolved
// operands are captured into per-source hold registers. A forwarded value
// therefore survives its producer leaving the forwarding window.
//
// Handshake: decode presents an instruction with de_valid. It is accepted
// (adv) only in a cycle where the dx slot is free, there is no load-use stall
// and no flush. Decode must keep the instruction stable while de_ready is 0.
// Execute consumes the dx contents in any cycle with dx_valid & ex_ready.
//
// Configuration macro: DE_STALL_COUNT_EN
//   defined   -> stall_count counts decode stall cycles, saturating.
//   undefined -> stall_count is tied to zero.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   de_valid, de_rs1/2, de_rd  decode instruction and register numbers
//   de_pc, de_imm, de_ctrl     decode PC, immediate, opaque control bundle
//   rf_rdata1/2                register-file read data
//   forward_rs1/2              forward selects (NOT / EX / MEM)
//   load_stall                 load-use hazard, hold decode
//   ex_fwd_data, mem_fwd_data  EX / MEM forwarded results
//   ex_ready                   execute accepts dx contents this cycle
//   flush                      kill decode instruction and dx register
//   de_ready                   decode may present a new instruction next cycle
//   dx_valid, dx_*             registered instruction for execute
//   stall_count                decode stall cycle counter
//   o_dbg_hold                 {source2, source1} hold FSM state (1 = HELD)
// -----------------------------------------------------------------------------
module de_ex_stage #(
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              de_valid,
  input  logic [4:0]        de_rs1,
  input  logic [4:0]        de_rs2,
  input  logic [4:0]        de_rd,
  input  logic [31:0]       de_pc,
  input  logic [31:0]       de_imm,
  input  logic [CTRL_W-1:0] de_ctrl,
  input  logic [31:0]       rf_rdata1,
  input  logic [31:0]       rf_rdata2,
  input  logic [1:0]        forward_rs1,
  input  logic [1:0]        forward_rs2,
  input  logic              load_stall,
  input  logic [31:0]       ex_fwd_data,
  input  logic [31:0]       mem_fwd_data,
  input  logic              ex_ready,
  input  logic              flush,
  output logic              de_ready,
  output logic              dx_valid,
  output logic [31:0]       dx_pc,
  output logic [31:0]       dx_imm,
  output logic [31:0]       dx_op1,
  output logic [31:0]       dx_op2,
  output logic [4:0]        dx_rd,
  output logic [CTRL_W-1:0] dx_ctrl,
  output logic [31:0]       stall_count,
  output logic [1:0]        o_dbg_hold
);

  localparam logic [1:0] NOT_FORWARDING = 2'b00;
  localparam logic [1:0] FORWARDING_EX  = 2'b01;
  localparam logic [1:0] FORWARDING_MEM = 2'b10;

  typedef enum logic {
    LIVE = 1'b0,
    HELD = 1'b1
  } hold_state_e;

  // Source register numbers are consumed by the forwarding unit upstream.
  logic w_unused_rs;
  assign w_unused_rs = ^{de_rs1, de_rs2};

  function automatic logic [31:0] fwd_mux(input logic [1:0]  sel,
                                          input logic [31:0] rf,
                                          input logic [31:0] ex,
                                          input logic [31:0] mem);
    logic [31:0] r;
    case (sel)
      NOT_FORWARDING: r = rf;
      FORWARDING_EX:  r = ex;
      FORWARDING_MEM: r = mem;
      default:        r = rf;  // unused encoding falls back to the RF
    endcase
    return r;
  endfunction

  function automatic hold_state_e hold_next(input hold_state_e cur,
                                            input logic        capture,
                                            input logic        release_h);
    hold_state_e n;
    n = cur;
    case (cur)
      LIVE:    if (capture)   n = HELD;
      HELD:    if (release_h) n = LIVE;
      default: n = LIVE;
    endcase
    return n;
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  hold_state_e       r_hold1_state;
  hold_state_e       r_hold2_state;
  logic [31:0]       r_held1;
  logic [31:0]       r_held2;
  logic              r_dx_valid;
  logic [31:0]       r_dx_pc;
  logic [31:0]       r_dx_imm;
  logic [31:0]       r_dx_op1;
  logic [31:0]       r_dx_op2;
  logic [4:0]        r_dx_rd;
  logic [CTRL_W-1:0] r_dx_ctrl;

  // ---------------------------------------------------------------------------
  // Combinational control and operand resolution
  // ---------------------------------------------------------------------------
  logic        w_slot_free;
  logic        w_adv;
  logic        w_capture;
  logic        w_release;
  logic [31:0] w_fwd1;
  logic [31:0] w_fwd2;
  logic [31:0] w_op1;
  logic [31:0] w_op2;
  hold_state_e w_hold1_next;
  hold_state_e w_hold2_next;

  assign w_slot_free = ~r_dx_valid | ex_ready;
  assign w_adv       = de_valid & ~load_stall & w_slot_free & ~flush;
  assign de_ready    = ~de_valid | w_adv | flush;

  // Capture only on a pure back-pressure block: during load_stall the
  // forwarded load data is not valid yet, so it must not be latched.
  assign w_capture = de_valid & ~w_adv & ~flush & ~load_stall;
  assign w_release = w_adv | flush;

  assign w_fwd1 = fwd_mux(forward_rs1, rf_rdata1, ex_fwd_data, mem_fwd_data);
  assign w_fwd2 = fwd_mux(forward_rs2, rf_rdata2, ex_fwd_data, mem_fwd_data);
  assign w_op1  = (r_hold1_state == HELD) ? r_held1 : w_fwd1;
  assign w_op2  = (r_hold2_state == HELD) ? r_held2 : w_fwd2;

  always_comb begin
    w_hold1_next = r_hold1_state;
    w_hold2_next = r_hold2_state;
    w_hold1_next = hold_next(r_hold1_state, w_capture, w_release);
    w_hold2_next = hold_next(r_hold2_state, w_capture, w_release);
  end

  // ---------------------------------------------------------------------------
  // Hold FSM state and held values
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold1_state <= LIVE;
      r_hold2_state <= LIVE;
    end else begin
      r_hold1_state <= w_hold1_next;
      r_hold2_state <= w_hold2_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_held1 <= 32'd0;
      r_held2 <= 32'd0;
    end else begin
      if (r_hold1_state == LIVE && w_capture) r_held1 <= w_fwd1;
      if (r_hold2_state == LIVE && w_capture) r_held2 <= w_fwd2;
    end
  end

  // ---------------------------------------------------------------------------
  // dx register: flush > adv > ex_ready (consume or bubble) > hold
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dx_valid <= 1'b0;
      r_dx_pc    <= 32'd0;
      r_dx_imm   <= 32'd0;
      r_dx_op1   <= 32'd0;
      r_dx_op2   <= 32'd0;
      r_dx_rd    <= 5'd0;
      r_dx_ctrl  <= '0;
    end else if (flush) begin
      r_dx_valid <= 1'b0;
    end else if (w_adv) begin
      r_dx_valid <= 1'b1;
      r_dx_pc    <= de_pc;
      r_dx_imm   <= de_imm;
      r_dx_op1   <= w_op1;
      r_dx_op2   <= w_op2;
      r_dx_rd    <= de_rd;
      r_dx_ctrl  <= de_ctrl;
    end else if (ex_ready) begin
      r_dx_valid <= 1'b0;
    end
  end

  assign dx_valid = r_dx_valid;
  assign dx_pc    = r_dx_pc;
  assign dx_imm   = r_dx_imm;
  assign dx_op1   = r_dx_op1;
  assign dx_op2   = r_dx_op2;
  assign dx_rd    = r_dx_rd;
  assign dx_ctrl  = r_dx_ctrl;

  assign o_dbg_hold = {r_hold2_state == HELD, r_hold1_state == HELD};

  // ---------------------------------------------------------------------------
  // Decode stall counter
  // ---------------------------------------------------------------------------
`ifdef DE_STALL_COUNT_EN
  logic [31:0] r_stall_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_count <= 32'd0;
    end else if (de_valid & ~w_adv & ~flush && r_stall_count != 32'hFFFF_FFFF) begin
      r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign stall_count = r_stall_count;
`else
  assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_de_ex_stage.sv
`timescale 1ns/1ps
// Testbench for de_ex_stage: table-driven cycle vectors with a scoreboard for
// the registered instruction data, plus hand-written reset and counter runs.
module tb_de_ex_stage;
  localparam int CTRL_W = 16;
  localparam int SB_W   = CTRL_W + 5 + 32 * 4;
  localparam logic [1:0] NOT_F = 2'd0;
  localparam logic [1:0] EX_F  = 2'd1;
  localparam logic [1:0] MEM_F = 2'd2;
  localparam logic [1:0] UNU_F = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              de_valid;
  logic [4:0]        de_rs1, de_rs2, de_rd;
  logic [31:0]       de_pc, de_imm;
  logic [CTRL_W-1:0] de_ctrl;
  logic [31:0]       rf_rdata1, rf_rdata2;
  logic [1:0]        forward_rs1, forward_rs2;
  logic              load_stall;
  logic [31:0]       ex_fwd_data, mem_fwd_data;
  logic              ex_ready;
  logic              flush;
  logic              de_ready;
  logic              dx_valid;
  logic [31:0]       dx_pc, dx_imm, dx_op1, dx_op2;
  logic [4:0]        dx_rd;
  logic [CTRL_W-1:0] dx_ctrl;
  logic [31:0]       stall_count;
  logic [1:0]        o_dbg_hold;

  de_ex_stage #(.CTRL_W(CTRL_W)) dut (
    .clk(clk), .reset(reset), .de_valid(de_valid),
    .de_rs1(de_rs1), .de_rs2(de_rs2), .de_rd(de_rd),
    .de_pc(de_pc), .de_imm(de_imm), .de_ctrl(de_ctrl),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .forward_rs1(forward_rs1), .forward_rs2(forward_rs2),
    .load_stall(load_stall), .ex_fwd_data(ex_fwd_data), .mem_fwd_data(mem_fwd_data),
    .ex_ready(ex_ready), .flush(flush), .de_ready(de_ready),
    .dx_valid(dx_valid), .dx_pc(dx_pc), .dx_imm(dx_imm),
    .dx_op1(dx_op1), .dx_op2(dx_op2), .dx_rd(dx_rd), .dx_ctrl(dx_ctrl),
    .stall_count(stall_count), .o_dbg_hold(o_dbg_hold)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [SB_W-1:0] exp_q[$];
  logic [31:0] cnt_m;
  logic [31:0] pc_n;

  typedef struct {
    logic dv, ls, er, fl;
    logic [1:0] f1, f2;
    logic [31:0] rf1, rf2, exd, memd;
    logic edr, edv;
    logic [1:0] eh;
    logic acc;
    logic [31:0] e1, e2;
  } vec_t;

  function automatic vec_t mk(input logic dv, input logic ls, input logic er, input logic fl,
                              input logic [1:0] f1, input logic [1:0] f2,
                              input logic [31:0] rf1, input logic [31:0] rf2,
                              input logic [31:0] exd, input logic [31:0] memd,
                              input logic edr, input logic edv, input logic [1:0] eh,
                              input logic acc, input logic [31:0] e1, input logic [31:0] e2);
    vec_t v;
    v.dv = dv; v.ls = ls; v.er = er; v.fl = fl; v.f1 = f1; v.f2 = f2;
    v.rf1 = rf1; v.rf2 = rf2; v.exd = exd; v.memd = memd;
    v.edr = edr; v.edv = edv; v.eh = eh; v.acc = acc; v.e1 = e1; v.e2 = e2;
    return v;
  endfunction

  function automatic logic [31:0] exp_cnt();
`ifdef DE_STALL_COUNT_EN
    return cnt_m;
`else
    return 32'd0;
`endif
  endfunction

  task automatic chk(input string name, input logic [SB_W-1:0] got, input logic [SB_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Drives one cycle, checks combinational de_ready before the edge, runs the
  // scoreboard, then checks registered state after the edge.
  task automatic apply(input vec_t v);
    logic [SB_W-1:0] e;
    de_valid = v.dv; load_stall = v.ls; ex_ready = v.er; flush = v.fl;
    forward_rs1 = v.f1; forward_rs2 = v.f2;
    rf_rdata1 = v.rf1; rf_rdata2 = v.rf2; ex_fwd_data = v.exd; mem_fwd_data = v.memd;
    de_pc = pc_n; de_imm = ~pc_n; de_rd = pc_n[6:2];
    de_ctrl = pc_n[15:0] ^ 16'h5A5A; de_rs1 = pc_n[4:0]; de_rs2 = pc_n[8:4];
    @(negedge clk);
    chk("de_ready", {{(SB_W-1){1'b0}}, de_ready}, {{(SB_W-1){1'b0}}, v.edr});
    if (dx_valid && flush) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else if (dx_valid && ex_ready && !reset) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL sb_empty: got dx_valid=1 with pc %h, required no instruction", dx_pc);
      end else begin
        e = exp_q.pop_front();
        chk("dx_data", {dx_ctrl, dx_rd, dx_imm, dx_pc, dx_op1, dx_op2}, e);
      end
    end
    if (reset) begin
      exp_q.delete();
      cnt_m = 32'd0;
    end else begin
      if (v.acc) exp_q.push_back({de_ctrl, de_rd, de_imm, de_pc, v.e1, v.e2});
      if (v.dv && !v.acc && !v.fl && cnt_m != 32'hFFFF_FFFF) cnt_m++;
    end
    @(posedge clk);
    #1;
    chk("dx_valid", {{(SB_W-1){1'b0}}, dx_valid}, {{(SB_W-1){1'b0}}, v.edv});
    chk("hold", {{(SB_W-2){1'b0}}, o_dbg_hold}, {{(SB_W-2){1'b0}}, v.eh});
    chk("stall_count", {{(SB_W-32){1'b0}}, stall_count}, {{(SB_W-32){1'b0}}, exp_cnt()});
    pc_n += 32'd4;
  endtask

  // ---------------- test ----------------
  vec_t tbl[19];

  initial begin
    logic [31:0] a, b, c, d, y, g, h, k, l;
    a = $urandom; b = $urandom; c = $urandom; d = $urandom; y = $urandom;
    g = $urandom; h = $urandom; k = $urandom; l = $urandom;
    cnt_m = 32'd0;
    pc_n  = 32'h0000_1000;

    // straight-line flow, EX forward, MEM / unused-encoding selects
    tbl[0]  = mk(1'b1,1'b0,1'b1,1'b0, NOT_F,NOT_F, 32'h11,32'h22,a,b, 1'b1,1'b1,2'd0, 1'b1,32'h11,32'h22);
    tbl[1]  = mk(1'b1,1'b0,1'b1,1'b0, NOT_F,EX_F,  c,32'h0,32'hABCD,d, 1'b1,1'b1,2'd0, 1'b1,c,32'hABCD);
    tbl[2]  = mk(1'b1,1'b0,1'b1,1'b0, MEM_F,UNU_F, a,b,c,d,          1'b1,1'b1,2'd0, 1'b1,d,b);
    // load-use stall: bubble, no capture; then advance with MEM data
    tbl[3]  = mk(1'b1,1'b1,1'b1,1'b0, MEM_F,MEM_F, a,b,c,d,          1'b0,1'b0,2'd0, 1'b0,32'h0,32'h0);
    tbl[4]  = mk(1'b1,1'b0,1'b1,1'b0, MEM_F,NOT_F, a,b,c,32'h77,     1'b1,1'b1,2'd0, 1'b1,32'h77,b);
    // back-pressure for 3 cycles; forwarded values captured in the first
    tbl[5]  = mk(1'b1,1'b0,1'b0,1'b0, MEM_F,EX_F,  a,b,y,32'h55,     1'b0,1'b1,2'd3, 1'b0,32'h0,32'h0);
    tbl[6]  = mk(1'b1,1'b0,1'b0,1'b0, NOT_F,NOT_F, 32'h99,c,d,a,     1'b0,1'b1,2'd3, 1'b0,32'h0,32'h0);
    tbl[7]  = mk(1'b1,1'b0,1'b0,1'b0, NOT_F,NOT_F, 32'h99,c,b,a,     1'b0,1'b1,2'd3, 1'b0,32'h0,32'h0);
    tbl[8]  = mk(1'b1,1'b0,1'b1,1'b0, NOT_F,NOT_F, 32'h99,c,d,a,     1'b1,1'b1,2'd0, 1'b1,32'h55,y);
    tbl[9]  = mk(1'b0,1'b0,1'b1,1'b0, NOT_F,NOT_F, a,b,c,d,          1'b1,1'b0,2'd0, 1'b0,32'h0,32'h0);
    // flush during back-pressure
    tbl[10] = mk(1'b1,1'b0,1'b1,1'b0, NOT_F,NOT_F, 32'hA0,32'hA1,c,d, 1'b1,1'b1,2'd0, 1'b1,32'hA0,32'hA1);
    tbl[11] = mk(1'b1,1'b0,1'b0,1'b0, NOT_F,NOT_F, 32'hB0,32'hB1,c,d, 1'b0,1'b1,2'd3, 1'b0,32'h0,32'h0);
    tbl[12] = mk(1'b1,1'b0,1'b0,1'b1, NOT_F,NOT_F, 32'hB0,32'hB1,c,d, 1'b1,1'b0,2'd0, 1'b0,32'h0,32'h0);
    tbl[13] = mk(1'b1,1'b0,1'b1,1'b0, NOT_F,NOT_F, 32'hC0,32'hC1,c,d, 1'b1,1'b1,2'd0, 1'b1,32'hC0,32'hC1);
    // flush together with a would-be advance: flush wins
    tbl[14] = mk(1'b1,1'b0,1'b1,1'b1, NOT_F,NOT_F, a,b,c,d,          1'b1,1'b0,2'd0, 1'b0,32'h0,32'h0);
    tbl[15] = mk(1'b0,1'b0,1'b0,1'b0, NOT_F,NOT_F, a,b,c,d,          1'b1,1'b0,2'd0, 1'b0,32'h0,32'h0);
    // load_stall with an empty slot and ex_ready low, then advance into it
    tbl[16] = mk(1'b1,1'b1,1'b0,1'b0, NOT_F,NOT_F, a,b,c,d,          1'b0,1'b0,2'd0, 1'b0,32'h0,32'h0);
    tbl[17] = mk(1'b1,1'b0,1'b0,1'b0, NOT_F,EX_F,  32'hD0,b,32'hD1,d, 1'b1,1'b1,2'd0, 1'b1,32'hD0,32'hD1);
    tbl[18] = mk(1'b0,1'b0,1'b1,1'b0, NOT_F,NOT_F, a,b,c,d,          1'b1,1'b0,2'd0, 1'b0,32'h0,32'h0);

    // reset
    reset = 1'b1; de_valid = 1'b0; load_stall = 1'b0; ex_ready = 1'b0; flush = 1'b0;
    forward_rs1 = NOT_F; forward_rs2 = NOT_F; rf_rdata1 = 32'h0; rf_rdata2 = 32'h0;
    ex_fwd_data = 32'h0; mem_fwd_data = 32'h0; de_pc = 32'h0; de_imm = 32'h0;
    de_rd = 5'd0; de_rs1 = 5'd0; de_rs2 = 5'd0; de_ctrl = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_dx_valid", {{(SB_W-1){1'b0}}, dx_valid}, '0);
    chk("rst_dx_data", {dx_ctrl, dx_rd, dx_imm, dx_pc, dx_op1, dx_op2}, '0);
    chk("rst_hold", {{(SB_W-2){1'b0}}, o_dbg_hold}, '0);
    chk("rst_stall_count", {{(SB_W-32){1'b0}}, stall_count}, '0);
    chk("rst_de_ready", {{(SB_W-1){1'b0}}, de_ready}, {{(SB_W-1){1'b0}}, 1'b1});

    for (int i = 0; i < 19; i++) apply(tbl[i]);

    // reset asserted mid-stall
    apply(mk(1'b1,1'b0,1'b1,1'b0, NOT_F,NOT_F, g,h,a,b, 1'b1,1'b1,2'd0, 1'b1,g,h));
    apply(mk(1'b1,1'b0,1'b0,1'b0, NOT_F,NOT_F, c,d,a,b, 1'b0,1'b1,2'd3, 1'b0,32'h0,32'h0));
    apply(mk(1'b1,1'b0,1'b0,1'b0, NOT_F,NOT_F, c,d,a,b, 1'b0,1'b1,2'd3, 1'b0,32'h0,32'h0));
    reset = 1'b1;
    apply(mk(1'b1,1'b0,1'b0,1'b0, NOT_F,NOT_F, c,d,a,b, 1'b0,1'b0,2'd0, 1'b0,32'h0,32'h0));
    reset = 1'b0;

    // counter: 4 back-pressure cycles from reset
    apply(mk(1'b1,1'b0,1'b1,1'b0, NOT_F,NOT_F, g,h,a,b, 1'b1,1'b1,2'd0, 1'b1,g,h));
    apply(mk(1'b1,1'b0,1'b0,1'b0, NOT_F,NOT_F, k,l,a,b, 1'b0,1'b1,2'd3, 1'b0,32'h0,32'h0));
    for (int i = 0; i < 3; i++)
      apply(mk(1'b1,1'b0,1'b0,1'b0, NOT_F,NOT_F, a,b,c,d, 1'b0,1'b1,2'd3, 1'b0,32'h0,32'h0));
`ifdef DE_STALL_COUNT_EN
    chk("stall_count_4", {{(SB_W-32){1'b0}}, stall_count}, {{(SB_W-32){1'b0}}, 32'd4});
`else
    chk("stall_count_off", {{(SB_W-32){1'b0}}, stall_count}, '0);
`endif
    apply(mk(1'b1,1'b0,1'b1,1'b0, NOT_F,NOT_F, a,b,c,d, 1'b1,1'b1,2'd0, 1'b1,k,l));
    apply(mk(1'b0,1'b0,1'b1,1'b0, NOT_F,NOT_F, a,b,c,d, 1'b1,1'b0,2'd0, 1'b0,32'h0,32'h0));

    chk("sb_left", exp_q.size(), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
